// File: rtl/brq_mem_arbiter.sv
// Arbitrates the brq instruction-fetch and data ports onto one req/gnt/rvalid memory port.
// Responses are routed back in order through a small owner-ID FIFO.
module brq_mem_arbiter #(
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          DataPriority   = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic [2:0]  outstanding_o,
   output logic        spurious_rsp_o
);

   localparam logic [2:0] MaxCnt  = 3'(MaxOutstanding);
   localparam logic [1:0] LastPtr = 2'(MaxOutstanding - 1);

   logic [2:0] count_q, count_d;
   logic [1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0] rd_ptr_q, rd_ptr_d;
   logic [3:0] owner_q, owner_d;
   logic       lock_q, lock_d;
   logic       lock_data_q, lock_data_d;
   logic       last_data_q, last_data_d;

   logic full, empty, owner_req, sel_data, sel_req, push, pop, head_data;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == LastPtr) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      full      = (count_q == MaxCnt);
      empty     = (count_q == 3'd0);
      owner_req = lock_data_q ? data_req_i : instr_req_i;

      // A lock whose owner dropped its request is ignored, so selection falls back to normal.
      if (lock_q && owner_req) begin
         sel_data = lock_data_q;
      end else if (DataPriority) begin
         sel_data = data_req_i;
      end else if (instr_req_i && data_req_i) begin
         sel_data = !last_data_q;
      end else begin
         sel_data = data_req_i;
      end

      sel_req     = sel_data ? data_req_i : instr_req_i;
      mem_req_o   = !full && sel_req;
      mem_we_o    = sel_data ? data_we_i    : 1'b0;
      mem_be_o    = sel_data ? data_be_i    : 4'hF;
      mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
      mem_wdata_o = sel_data ? data_wdata_i : 32'h0;

      push        = mem_req_o && mem_gnt_i;
      pop         = mem_rvalid_i && !empty;
      instr_gnt_o = push && !sel_data;
      data_gnt_o  = push && sel_data;

      head_data      = owner_q[rd_ptr_q];
      instr_rvalid_o = pop && !head_data;
      data_rvalid_o  = pop && head_data;
      instr_rdata_o  = mem_rdata_i;
      data_rdata_o   = mem_rdata_i;
      instr_err_o    = mem_err_i;
      data_err_o     = mem_err_i;
      spurious_rsp_o = mem_rvalid_i && empty;
      outstanding_o  = count_q;
   end

   always_comb begin
      owner_d  = owner_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         owner_d[wr_ptr_q] = sel_data;
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase

      // Hold the selection while the host stalls so req/addr stay stable until grant.
      lock_d      = mem_req_o && !mem_gnt_i;
      lock_data_d = lock_d ? sel_data : lock_data_q;
      last_data_d = push ? sel_data : last_data_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q     <= 3'd0;
         wr_ptr_q    <= 2'd0;
         rd_ptr_q    <= 2'd0;
         owner_q     <= 4'd0;
         lock_q      <= 1'b0;
         lock_data_q <= 1'b0;
         last_data_q <= 1'b1;
      end else begin
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         owner_q     <= owner_d;
         lock_q      <= lock_d;
         lock_data_q <= lock_data_d;
         last_data_q <= last_data_d;
      end
   end

   a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_q <= MaxCnt);
   a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(instr_gnt_o && data_gnt_o));
   a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(instr_rvalid_o && data_rvalid_o));
   a_lock_owner_holds_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
      lock_q |-> owner_req);

endmodule

// File: tb/tb_brq_mem_arbiter.sv
// Directed bench for brq_mem_arbiter: a data-priority instance and a round-robin instance
// share the same stimulus; each scenario checks against hand-computed values.
module tb_brq_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err;
   logic [3:0]  data_be;
   logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;

   logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
   logic        mem_req, mem_we, spurious;
   logic [3:0]  mem_be;
   logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
   logic [2:0]  outstanding;

   logic        rr_instr_gnt, rr_instr_rvalid, rr_instr_err, rr_data_gnt, rr_data_rvalid;
   logic        rr_data_err, rr_mem_req, rr_mem_we, rr_spurious;
   logic [3:0]  rr_mem_be;
   logic [31:0] rr_instr_rdata, rr_data_rdata, rr_mem_addr, rr_mem_wdata;
   logic [2:0]  rr_outstanding;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   brq_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b1)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
      .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
      .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
      .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
      .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .outstanding_o(outstanding), .spurious_rsp_o(spurious)
   );

   brq_mem_arbiter #(.MaxOutstanding(2), .DataPriority(1'b0)) u_dut_rr (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .instr_req_i(instr_req), .instr_gnt_o(rr_instr_gnt), .instr_rvalid_o(rr_instr_rvalid),
      .instr_addr_i(instr_addr), .instr_rdata_o(rr_instr_rdata), .instr_err_o(rr_instr_err),
      .data_req_i(data_req), .data_gnt_o(rr_data_gnt), .data_rvalid_o(rr_data_rvalid),
      .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
      .data_wdata_i(data_wdata), .data_rdata_o(rr_data_rdata), .data_err_o(rr_data_err),
      .mem_req_o(rr_mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
      .mem_we_o(rr_mem_we), .mem_be_o(rr_mem_be), .mem_addr_o(rr_mem_addr),
      .mem_wdata_o(rr_mem_wdata), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
      .outstanding_o(rr_outstanding), .spurious_rsp_o(rr_spurious)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #7;
      rst_ni = 1'b1;
      tick();
   endtask

   initial begin
      rst_ni = 1'b0;
      {instr_req, data_req, data_we, mem_gnt, mem_rvalid, mem_err} = '0;
      data_be = 4'h0; instr_addr = '0; data_addr = '0; data_wdata = '0; mem_rdata = '0;
      #12;
      check_eq("rst_mem_req", 32'(mem_req), 32'd0);
      check_eq("rst_outstanding", 32'(outstanding), 32'd0);
      check_eq("rst_gnts", 32'({instr_gnt, data_gnt}), 32'd0);
      check_eq("rst_rvalids", 32'({instr_rvalid, data_rvalid}), 32'd0);
      check_eq("rst_spurious", 32'(spurious), 32'd0);
      rst_ni = 1'b1;
      tick();

      // Single fetch
      instr_req = 1'b1; instr_addr = 32'h0000_0080; mem_gnt = 1'b1;
      settle();
      check_eq("fetch_gnt", 32'({instr_gnt, data_gnt}), 32'b10);
      check_eq("fetch_addr", mem_addr, 32'h0000_0080);
      check_eq("fetch_be_we", 32'({mem_be, mem_we}), 32'b11110);
      tick();
      instr_req = 1'b0; mem_gnt = 1'b0;
      check_eq("fetch_outstanding", 32'(outstanding), 32'd1);
      mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093;
      settle();
      check_eq("fetch_rvalid", 32'({instr_rvalid, data_rvalid}), 32'b10);
      check_eq("fetch_rdata", instr_rdata, 32'h0010_0093);
      tick();
      mem_rvalid = 1'b0;
      check_eq("fetch_drained", 32'(outstanding), 32'd0);

      // Contention with data priority
      instr_req = 1'b1; instr_addr = 32'h0000_0100;
      data_req = 1'b1; data_addr = 32'h0000_2000; data_we = 1'b1; data_be = 4'b0011;
      data_wdata = 32'hDEAD_BEEF; mem_gnt = 1'b1;
      settle();
      check_eq("cont_addr", mem_addr, 32'h0000_2000);
      check_eq("cont_be", 32'(mem_be), 32'h3);
      check_eq("cont_we", 32'(mem_we), 32'd1);
      check_eq("cont_wdata", mem_wdata, 32'hDEAD_BEEF);
      check_eq("cont_gnt", 32'({instr_gnt, data_gnt}), 32'b01);
      tick();
      data_req = 1'b0; data_we = 1'b0;
      settle();
      check_eq("cont_instr_gnt", 32'({instr_gnt, data_gnt}), 32'b10);
      check_eq("cont_instr_addr", mem_addr, 32'h0000_0100);
      check_eq("cont_outst1", 32'(outstanding), 32'd1);
      tick();
      instr_req = 1'b0; mem_gnt = 1'b0;
      check_eq("cont_outst2", 32'(outstanding), 32'd2);
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
      settle();
      check_eq("cont_rsp1", 32'({instr_rvalid, data_rvalid}), 32'b01);
      check_eq("cont_rsp1_data", data_rdata, 32'h0000_0011);
      tick();
      mem_rdata = 32'h0000_0022;
      settle();
      check_eq("cont_rsp2", 32'({instr_rvalid, data_rvalid}), 32'b10);
      tick();
      mem_rvalid = 1'b0;
      check_eq("cont_drained", 32'(outstanding), 32'd0);

      // Lock: instr stalled, data arrives mid-stall
      instr_req = 1'b1; instr_addr = 32'h0000_0300;
      settle();
      check_eq("lock_c1_addr", mem_addr, 32'h0000_0300);
      tick();
      data_req = 1'b1; data_addr = 32'h0000_0400; data_be = 4'hF;
      settle();
      check_eq("lock_c2_addr", mem_addr, 32'h0000_0300);
      check_eq("lock_c2_gnt", 32'({instr_gnt, data_gnt}), 32'b00);
      tick();
      settle();
      check_eq("lock_c3_addr", mem_addr, 32'h0000_0300);
      tick();
      mem_gnt = 1'b1;
      settle();
      check_eq("lock_first_gnt", 32'({instr_gnt, data_gnt}), 32'b10);
      tick();
      instr_req = 1'b0;
      settle();
      check_eq("lock_second_gnt", 32'({instr_gnt, data_gnt}), 32'b01);
      check_eq("lock_second_addr", mem_addr, 32'h0000_0400);
      tick();
      data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
      settle();
      check_eq("lock_rsp1", 32'({instr_rvalid, data_rvalid}), 32'b10);
      tick();
      settle();
      check_eq("lock_rsp2", 32'({instr_rvalid, data_rvalid}), 32'b01);
      tick();
      mem_rvalid = 1'b0;

      // Round-robin instance: fresh reset so instr wins first contention
      do_reset();
      instr_req = 1'b1; instr_addr = 32'h0000_0500;
      data_req = 1'b1; data_addr = 32'h0000_0600; mem_gnt = 1'b1;
      settle();
      check_eq("rr_c1_gnt", 32'({rr_instr_gnt, rr_data_gnt}), 32'b10);
      check_eq("rr_c1_addr", rr_mem_addr, 32'h0000_0500);
      tick();
      mem_rvalid = 1'b1;
      settle();
      check_eq("rr_c2_gnt", 32'({rr_instr_gnt, rr_data_gnt}), 32'b01);
      check_eq("rr_c2_rsp", 32'({rr_instr_rvalid, rr_data_rvalid}), 32'b10);
      tick();
      settle();
      check_eq("rr_c3_gnt", 32'({rr_instr_gnt, rr_data_gnt}), 32'b10);
      check_eq("rr_c3_rsp", 32'({rr_instr_rvalid, rr_data_rvalid}), 32'b01);
      tick();
      settle();
      check_eq("rr_c4_gnt", 32'({rr_instr_gnt, rr_data_gnt}), 32'b01);
      check_eq("rr_c4_rsp", 32'({rr_instr_rvalid, rr_data_rvalid}), 32'b10);
      tick();
      instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
      settle();
      check_eq("rr_c5_rsp", 32'({rr_instr_rvalid, rr_data_rvalid}), 32'b01);
      tick();
      mem_rvalid = 1'b0;
      check_eq("rr_drained", 32'(rr_outstanding), 32'd0);

      // Full stall
      instr_req = 1'b1; instr_addr = 32'h0000_0700; mem_gnt = 1'b1;
      tick();
      tick();
      check_eq("full_outst", 32'(outstanding), 32'd2);
      check_eq("full_no_req", 32'(mem_req), 32'd0);
      check_eq("full_no_gnt", 32'(instr_gnt), 32'd0);
      mem_rvalid = 1'b1;
      settle();
      check_eq("full_pop_no_req", 32'(mem_req), 32'd0);
      tick();
      mem_rvalid = 1'b0;
      check_eq("full_after_pop", 32'(outstanding), 32'd1);
      check_eq("full_reissue_req", 32'(mem_req), 32'd1);
      check_eq("full_reissue_gnt", 32'(instr_gnt), 32'd1);
      tick();
      instr_req = 1'b0; mem_gnt = 1'b0;
      check_eq("full_outst_again", 32'(outstanding), 32'd2);

      // Async reset with two outstanding
      settle();
      rst_ni = 1'b0;
      #1;
      check_eq("arst_outst", 32'(outstanding), 32'd0);
      #2;
      rst_ni = 1'b1;
      tick();

      // Lock cleared by reset: instr locked, then reset exposes data priority again
      instr_req = 1'b1; instr_addr = 32'h0000_0700;
      tick();
      data_req = 1'b1; data_addr = 32'h0000_0800;
      settle();
      check_eq("lockrst_locked_addr", mem_addr, 32'h0000_0700);
      rst_ni = 1'b0;
      #1;
      check_eq("lockrst_cleared_addr", mem_addr, 32'h0000_0800);
      instr_req = 1'b0; data_req = 1'b0;
      #2;
      rst_ni = 1'b1;
      tick();

      // Spurious response
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
      settle();
      check_eq("spur_pulse", 32'(spurious), 32'd1);
      check_eq("spur_no_rvalid", 32'({instr_rvalid, data_rvalid}), 32'b00);
      tick();
      mem_rvalid = 1'b0;
      settle();
      check_eq("spur_clear", 32'(spurious), 32'd0);
      check_eq("spur_outst", 32'(outstanding), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
